// File: rtl/prog_mem_sequencer.sv
// prog_mem_sequencer: streams host images into shared memory, dumps them back, and supervises CPU runs
module prog_mem_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter int CNT_W = 32,
  parameter int MAX_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              abort,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] Ext_Mem_Addr,
  output logic [DATA_W-1:0] Ext_MemW_Data,
  output logic              Mem_Addr_Sel,
  output logic              MemW_Data_Sel,
  output logic              MemW_en,
  output logic              cpu_run,
  input  logic              cpu_halt,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              done,
  output logic [1:0]        status
);
  typedef enum logic [2:0] {IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, RUN} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] base, len, idx, cur_addr, idx_inc, wa;
  logic [DATA_W-1:0] wd;
  logic [2:0] wcnt;
  logic we, accept, wr_hs, rd_hs, tmo_hit, quit, done_n, dump_phase;
  logic [1:0] status_n;
  assign accept = cmd_valid & cmd_ready;
  assign wr_hs = wr_valid & wr_ready;
  assign rd_hs = rd_valid & rd_ready;
  assign cur_addr = base + idx;
  assign idx_inc = idx + ADDR_W'(1);
  assign tmo_hit = cycle_count == CNT_W'(MAX_CYCLES - 1);
  assign quit = abort & (state != IDLE);
  assign done_n = (next == IDLE) & ((state != IDLE) | accept);
  assign status_n = quit ? 2'b11 : state == RUN ? (cpu_halt ? 2'b01 : 2'b10) : 2'b00;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: if (accept) next = (cmd_op == 2'b11 || (cmd_op != 2'b10 && cmd_len == '0)) ? IDLE :
                               cmd_op == 2'b00 ? LOAD : cmd_op == 2'b01 ? DUMP_ADDR : RUN;
      LOAD: next = idx == len ? IDLE : LOAD;
      DUMP_ADDR: next = DUMP_WAIT;
      DUMP_WAIT: next = wcnt == 3'(RD_LAT - 1) ? DUMP_OUT : DUMP_WAIT;
      DUMP_OUT: next = !rd_hs ? DUMP_OUT : idx_inc == len ? IDLE : DUMP_ADDR;
      RUN: next = (cpu_halt | tmo_hit) ? IDLE : RUN;
      default: next = IDLE;
    endcase
    if (quit) next = IDLE;
  end
  always_comb begin
    dump_phase = state == DUMP_ADDR || state == DUMP_WAIT;
    cmd_ready = state == IDLE && !done;
    wr_ready = state == LOAD && idx < len && !abort;
    rd_valid = state == DUMP_OUT;
    cpu_run = state == RUN;
    MemW_en = we;
    MemW_Data_Sel = we;
    Mem_Addr_Sel = we | dump_phase;
    Ext_Mem_Addr = we ? wa : dump_phase ? cur_addr : '0;
    Ext_MemW_Data = we ? wd : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base <= '0;
      len <= '0;
      idx <= '0;
      wcnt <= '0;
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
      rd_data <= '0;
      rd_addr <= '0;
      cycle_count <= '0;
      done <= 1'b0;
      status <= 2'b00;
    end else begin
      done <= done_n;
      we <= wr_hs;
      wcnt <= state == DUMP_WAIT ? wcnt + 3'd1 : 3'd0;
      status <= done_n ? status_n : accept ? 2'b00 : status;
      if (wr_hs) begin
        wa <= cur_addr;
        wd <= wr_data;
      end
      if (accept) begin
        base <= cmd_base;
        len <= cmd_len;
        idx <= '0;
      end else if (wr_hs || rd_hs) idx <= idx_inc;
      if (state == DUMP_WAIT && next == DUMP_OUT) begin
        rd_data <= mem_rdata;
        rd_addr <= cur_addr;
      end
      if (accept && cmd_op == 2'b10) cycle_count <= '0;
      else if (state == RUN) cycle_count <= cycle_count + CNT_W'(1);
    end
endmodule
